// File: rtl/program_executor.sv
// Purpose : fetch/decode/execute engine for 18-bit switch-entered programs on an 8x8-bit register file.
// Latency : 2 cycles per instruction (FETCH then EXEC); done/fault one cycle after the ending FETCH/EXEC.
// Backpressure: none; start is a level sampled only in IDLE/DONE/FAULT and ignored while busy.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start               begin a run (level, sampled when not busy)
//   prog_bus            NUM_SLOTS x 18-bit slots, slot k = prog_bus[18*k +: 18]
//   last_index          index of last valid slot (clamped to NUM_SLOTS-1)
//   dbg_sel / dbg_data  combinational register read port
//   pc, zero, carry     program counter and ALU flags
//   busy, done, fault   run status
module program_executor #(
    parameter int NUM_SLOTS = 10,
    parameter int MAX_STEPS = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [18*NUM_SLOTS-1:0]   prog_bus,
    input  logic [3:0]                last_index,
    input  logic [2:0]                dbg_sel,
    output logic [7:0]                dbg_data,
    output logic [3:0]                pc,
    output logic                      zero,
    output logic                      carry,
    output logic                      busy,
    output logic                      done,
    output logic                      fault
);

    localparam int              SW         = $clog2(MAX_STEPS + 1);
    localparam logic [4:0]      SLOTS      = 5'(NUM_SLOTS);
    localparam logic [SW-1:0]   STEP_LIMIT = SW'(MAX_STEPS);
    localparam logic [SW-1:0]   STEP_ONE   = SW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DONE,
        S_FAULT
    } state_t;

    state_t          state, state_nxt;
    logic [17:0]     ir, ir_nxt;
    logic [3:0]      pc_nxt;
    logic            zero_nxt, carry_nxt;
    logic [SW-1:0]   steps, steps_nxt;
    logic [7:0]      regs [8];

    logic            reg_we;
    logic [2:0]      reg_wa;
    logic [7:0]      reg_wd;

    logic [3:0]      op;
    logic [2:0]      rd, rs;
    logic [7:0]      imm;
    logic [7:0]      a, b;
    logic [8:0]      alu;
    logic            flags_upd, jump, halt;
    logic [17:0]     slot;
    logic [4:0]      eff_last;

    assign op  = ir[17:14];
    assign rd  = ir[13:11];
    assign rs  = ir[10:8];
    assign imm = ir[7:0];

    // Both operands are read before the write-back, so rd==rs ops see pre-EXEC values.
    assign a = regs[rd];
    assign b = regs[rs];

    // Slot mux written as a compare chain so an out-of-range pc never indexes past the bus.
    always_comb begin
        slot = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (pc == 4'(k)) begin
                slot = prog_bus[18*k +: 18];
            end
        end
    end

    // A last_index beyond the populated slots is clamped to the final slot.
    always_comb begin
        if ({1'b0, last_index} >= SLOTS) begin
            eff_last = SLOTS - 5'd1;
        end else begin
            eff_last = {1'b0, last_index};
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        zero_nxt  = zero;
        carry_nxt = carry;
        steps_nxt = steps;
        reg_we    = 1'b0;
        reg_wa    = rd;
        reg_wd    = '0;
        alu       = '0;
        flags_upd = 1'b0;
        jump      = 1'b0;
        halt      = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_FAULT: begin
                if (start) begin
                    state_nxt = S_FETCH;
                    pc_nxt    = '0;
                    zero_nxt  = 1'b0;
                    carry_nxt = 1'b0;
                    steps_nxt = '0;
                end
            end

            S_FETCH: begin
                // Running off the end of the program is a normal completion.
                if ({1'b0, pc} > eff_last) begin
                    state_nxt = S_DONE;
                end else begin
                    ir_nxt    = slot;
                    state_nxt = S_EXEC;
                end
            end

            S_EXEC: begin
                steps_nxt = steps + STEP_ONE;
                pc_nxt    = pc + 4'd1;
                state_nxt = S_FETCH;

                case (op)
                    4'd1: begin reg_we = 1'b1; reg_wd = imm; end
                    4'd2: begin reg_we = 1'b1; reg_wd = b;   end
                    4'd3: begin alu = {1'b0, a} + {1'b0, b};   flags_upd = 1'b1; end
                    // Borrow shows up in bit 8 of the 9-bit difference.
                    4'd4: begin alu = {1'b0, a} - {1'b0, b};   flags_upd = 1'b1; end
                    4'd5: begin alu = {1'b0, a & b};           flags_upd = 1'b1; end
                    4'd6: begin alu = {1'b0, a | b};           flags_upd = 1'b1; end
                    4'd7: begin alu = {1'b0, a ^ b};           flags_upd = 1'b1; end
                    4'd8: begin alu = {1'b0, a} + {1'b0, imm}; flags_upd = 1'b1; end
                    4'd9:  jump = 1'b1;
                    4'd10: jump = (a == 8'd0);
                    4'd11: halt = 1'b1;
                    default: ;
                endcase

                if (flags_upd) begin
                    reg_we    = 1'b1;
                    reg_wd    = alu[7:0];
                    zero_nxt  = (alu[7:0] == 8'd0);
                    carry_nxt = alu[8];
                end

                if (halt) begin
                    state_nxt = S_DONE;
                    pc_nxt    = pc;
                end else if (jump && ({1'b0, imm[3:0]} >= SLOTS)) begin
                    // Leave pc on the offending jump so it can be read off the LEDs.
                    state_nxt = S_FAULT;
                    pc_nxt    = pc;
                end else begin
                    if (jump) begin
                        pc_nxt = imm[3:0];
                    end
                    if (steps_nxt >= STEP_LIMIT) begin
                        state_nxt = S_FAULT;
                    end
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc    <= '0;
            ir    <= '0;
            zero  <= 1'b0;
            carry <= 1'b0;
            steps <= '0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            zero  <= zero_nxt;
            carry <= carry_nxt;
            steps <= steps_nxt;
            if (reg_we) begin
                regs[reg_wa] <= reg_wd;
            end
        end
    end

    assign dbg_data = regs[dbg_sel];
    assign busy     = (state == S_FETCH) || (state == S_EXEC);
    assign done     = (state == S_DONE);
    assign fault    = (state == S_FAULT);

endmodule

// File: tb/tb_program_executor.sv
module tb_program_executor;

    localparam int NS   = 10;
    localparam int MAXS = 255;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [18*NS-1:0] prog_bus;
    logic [3:0]       last_index;
    logic [2:0]       dbg_sel;
    logic [7:0]       dbg_data;
    logic [3:0]       pc;
    logic             zero, carry, busy, done, fault;

    logic [17:0]      prog [NS];

    program_executor #(.NUM_SLOTS(NS), .MAX_STEPS(MAXS)) dut (
        .clock(clock), .reset(reset), .start(start), .prog_bus(prog_bus),
        .last_index(last_index), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .pc(pc), .zero(zero), .carry(carry), .busy(busy), .done(done), .fault(fault)
    );

    always #5 clock = ~clock;

    always_comb begin
        prog_bus = '0;
        for (int k = 0; k < NS; k++) prog_bus[18*k +: 18] = prog[k];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [17:0] enc(input int op, input int rd, input int rs, input int imm);
        logic [3:0] o;
        logic [2:0] d, s;
        logic [7:0] i;
        o = 4'(op); d = 3'(rd); s = 3'(rs); i = 8'(imm);
        return {o, d, s, i};
    endfunction

    // Instruction-level reference: architectural state after a whole run.
    int e_regs [8];
    int e_zero, e_carry, e_pc, e_fault, e_busy;

    task automatic model_run();
        int p, n, eff, op, rd, rs, imm, a, b, s, tgt;
        bit taken;
        logic [17:0] w;
        eff = (int'(last_index) >= NS) ? NS - 1 : int'(last_index);
        p = 0; n = 0; e_zero = 0; e_carry = 0;
        while (1) begin
            if (p > eff) begin e_fault = 0; e_busy = 2*n + 1; break; end
            w   = prog[p];
            op  = int'(w[17:14]); rd = int'(w[13:11]); rs = int'(w[10:8]); imm = int'(w[7:0]);
            n++;
            a = e_regs[rd]; b = e_regs[rs];
            case (op)
                1: e_regs[rd] = imm;
                2: e_regs[rd] = b;
                3: begin s = a + b;   e_regs[rd] = s % 256; e_carry = (s > 255); e_zero = (s % 256 == 0); end
                4: begin s = (a - b + 256) % 256; e_regs[rd] = s; e_carry = (a < b); e_zero = (s == 0); end
                5: begin s = a & b;   e_regs[rd] = s; e_carry = 0; e_zero = (s == 0); end
                6: begin s = a | b;   e_regs[rd] = s; e_carry = 0; e_zero = (s == 0); end
                7: begin s = a ^ b;   e_regs[rd] = s; e_carry = 0; e_zero = (s == 0); end
                8: begin s = a + imm; e_regs[rd] = s % 256; e_carry = (s > 255); e_zero = (s % 256 == 0); end
                default: ;
            endcase
            if (op == 11) begin e_fault = 0; e_busy = 2*n; break; end
            taken = (op == 9) || (op == 10 && a == 0);
            tgt   = imm % 16;
            if (taken && tgt >= NS) begin e_fault = 1; e_busy = 2*n; break; end
            p = taken ? tgt : p + 1;
            if (n >= MAXS) begin e_fault = 1; e_busy = 2*n; break; end
        end
        e_pc = p;
    endtask

    // phase 1: run in progress, phase 2: terminal state holding
    int phase = 0;
    int cyc   = 0;

    always @(negedge clock) begin
        if (phase == 1) begin
            cyc++;
            if (cyc == 1) begin
                check("start_pc", pc, 0);
                check("start_zero", zero, 0);
                check("start_carry", carry, 0);
            end
            if (cyc <= e_busy) begin
                check("busy_run", busy, 1);
                check("done_early", done, 0);
                check("fault_early", fault, 0);
            end else begin
                check("end_done", done, !e_fault);
                check("end_fault", fault, e_fault);
                check("end_busy", busy, 0);
                check("end_pc", pc, e_pc);
                check("end_zero", zero, e_zero);
                check("end_carry", carry, e_carry);
                phase = 2;
            end
        end else if (phase == 2) begin
            check("hold_done", done, !e_fault);
            check("hold_fault", fault, e_fault);
            check("dbg_reg", dbg_data, e_regs[dbg_sel]);
        end
    end

    task automatic clear_prog();
        for (int k = 0; k < NS; k++) prog[k] = '0;
    endtask

    task automatic run(input int hold);
        model_run();
        start = 1'b1;
        @(posedge clock);
        #1;
        cyc = 0;
        phase = 1;
        if (hold == 0) start = 1'b0;
        repeat (hold) @(posedge clock);
        #1 start = 1'b0;
        for (int i = 0; i < e_busy + 20; i++) begin
            @(negedge clock);
            if (phase != 1) break;
        end
        if (phase != 2) begin
            check("run_timeout", phase, 2);
            phase = 0;
        end else begin
            for (int r = 0; r < 8; r++) begin
                @(posedge clock);
                #1 dbg_sel = 3'(r);
                @(negedge clock);
            end
            @(posedge clock);
            #1 phase = 0;
        end
    endtask

    task automatic lit_reg(input string nm, input int r, input int v);
        dbg_sel = 3'(r);
        #1;
        check(nm, dbg_data, v);
    endtask

    task automatic load_prog1();
        clear_prog();
        prog[0] = enc(1, 1, 0, 5);
        prog[1] = enc(1, 2, 0, 3);
        prog[2] = enc(3, 1, 2, 0);
        last_index = 4'd2;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; last_index = '0; dbg_sel = '0;
        clear_prog();
        for (int r = 0; r < 8; r++) e_regs[r] = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_pc", pc, 0);
        check("rst_zero", zero, 0);
        check("rst_carry", carry, 0);
        for (int r = 0; r < 8; r++) lit_reg("rst_reg", r, 0);

        // 1: basic add
        load_prog1();
        run(0);
        lit_reg("t1_r1", 1, 8);

        // 2: carry out of ADDI, then self-subtract
        clear_prog();
        prog[0] = enc(1, 0, 0, 200);
        prog[1] = enc(8, 0, 0, 100);
        prog[2] = enc(4, 0, 0, 0);
        last_index = 4'd1;
        run(0);
        lit_reg("t2a_r0", 0, 44);
        check("t2a_carry", carry, 1);
        last_index = 4'd2;
        run(0);
        lit_reg("t2b_r0", 0, 0);
        check("t2b_zero", zero, 1);

        // 4a: infinite loop trips the step guard
        clear_prog();
        prog[0] = enc(9, 0, 0, 0);
        last_index = 4'd0;
        run(0);
        check("t4a_fault", fault, 1);
        // 4b: jump past the populated slots
        prog[0] = enc(9, 0, 0, 12);
        run(0);
        check("t4b_pc", pc, 0);

        // 3: taken BEQZ skips an LDI, HALT holds pc (restart from FAULT)
        clear_prog();
        prog[0] = enc(1, 3, 0, 0);
        prog[1] = enc(10, 3, 0, 3);
        prog[2] = enc(1, 4, 0, 9);
        prog[3] = enc(11, 0, 0, 0);
        last_index = 4'd3;
        run(0);
        check("t3_pc", pc, 3);
        lit_reg("t3_r4", 4, 0);

        // out-of-range last_index clamps to the final slot
        clear_prog();
        for (int k = 0; k < NS; k++) prog[k] = enc(8, 5, 0, 1);
        last_index = 4'd15;
        run(0);
        check("clamp_pc", pc, 10);
        lit_reg("clamp_r5", 5, 10);

        // logic ops, MOV, NOP encodings, same-register ADD, LDI leaves flags alone
        clear_prog();
        prog[0] = enc(1, 1, 0, 8'hF0);
        prog[1] = enc(1, 2, 0, 8'h3C);
        prog[2] = enc(2, 3, 1, 0);
        prog[3] = enc(7, 3, 2, 0);
        prog[4] = enc(6, 1, 2, 0);
        prog[5] = enc(5, 2, 1, 0);
        prog[6] = enc(13, 7, 7, 8'hFF);
        prog[7] = enc(3, 3, 3, 0);
        prog[8] = enc(1, 6, 0, 0);
        last_index = 4'd8;
        run(0);
        lit_reg("mix_r3", 3, 8'h98);
        lit_reg("mix_r1", 1, 8'hFC);
        check("mix_carry", carry, 1);

        // 5: reset in the middle of program 1
        load_prog1();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        lit_reg("t5_mid_r1", 1, 5);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_pc", pc, 0);
        check("t5_done", done, 0);
        for (int r = 0; r < 8; r++) begin
            e_regs[r] = 0;
            lit_reg("t5_reg", r, 0);
        end

        // 6: clean rerun, then rerun from DONE with start held while busy
        run(0);
        run(3);
        lit_reg("t6_r1", 1, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
